// File: rtl/vec_pkg.sv
// -----------------------------------------------------------------------------
// vec_pkg
// Shared types for the vector command dispatcher: opcode encoding, the packed
// command record carried through the command FIFO and hold register, the
// dispatch FSM state encoding and the legal-opcode helper.
// The widths below describe the default accelerator geometry (8 vectors,
// 8 elements of 8 bits); the dispatcher parameters must be kept equal to them.
// -----------------------------------------------------------------------------
package vec_pkg;

    localparam int VEC_ELS    = 8;
    localparam int VEC_LEN    = 8;
    localparam int VEC_DW     = 8;
    localparam int VEC_ADDR_W = $clog2(VEC_ELS);
    localparam int VEC_DATA_W = VEC_LEN * VEC_DW;

    typedef enum logic [3:0] {
        OP_ADD  = 4'b0000,
        OP_SUB  = 4'b0001,
        OP_MUL  = 4'b0010,
        OP_FMA  = 4'b0011,
        OP_ADDS = 4'b0100,
        OP_SUBS = 4'b0101,
        OP_MULS = 4'b0110,
        OP_RD   = 4'b1000,
        OP_WR   = 4'b1001
    } vec_op_e;

    // The opcode is kept as raw bits so that illegal encodings can travel
    // through the FIFO and be recognised at the pop point.
    typedef struct packed {
        logic [3:0]            op;
        logic [VEC_ADDR_W-1:0] addr_a;
        logic [VEC_ADDR_W-1:0] addr_b;
        logic [VEC_ADDR_W-1:0] addr_c;
        logic [VEC_ADDR_W-1:0] addr_d;
        logic [VEC_DW-1:0]     scalar;
        logic [VEC_DATA_W-1:0] w_data;
    } vec_cmd_s;

    typedef enum logic [1:0] {
        s_IDLE  = 2'd0,
        s_ISSUE = 2'd1,
        s_BUSY  = 2'd2,
        s_RESP  = 2'd3
    } disp_state_e;

    function automatic logic is_legal_op(input logic [3:0] op);
        return (op <= 4'b0110) || (op == OP_RD) || (op == OP_WR);
    endfunction

endpackage

// File: rtl/vec_cmd_fifo.sv
// -----------------------------------------------------------------------------
// vec_cmd_fifo
// Synchronous FIFO of vec_cmd_s records. Depth must be a power of two >= 2.
// Read and write pointers carry one extra wrap bit so full and empty are
// distinguished without a separate counter.
// Ports:
//   clk_i, reset_ni      clock, asynchronous active-low reset
//   wr_en_i, wr_data_i   push (caller guarantees !full_o)
//   rd_en_i, rd_data_o   pop (caller guarantees !empty_o); rd_data_o = head
//   full_o, empty_o      occupancy flags
// -----------------------------------------------------------------------------
module vec_cmd_fifo
    import vec_pkg::*;
#(
    parameter int fifo_els_p = 4
) (
    input  logic     clk_i,
    input  logic     reset_ni,
    input  logic     wr_en_i,
    input  vec_cmd_s wr_data_i,
    input  logic     rd_en_i,
    output vec_cmd_s rd_data_o,
    output logic     full_o,
    output logic     empty_o
);

    localparam int aw_lp = $clog2(fifo_els_p);

    vec_cmd_s         mem_q [fifo_els_p];
    logic [aw_lp:0]   wr_ptr_q, wr_ptr_d;
    logic [aw_lp:0]   rd_ptr_q, rd_ptr_d;

    assign wr_ptr_d = wr_en_i ? wr_ptr_q + 1'b1 : wr_ptr_q;
    assign rd_ptr_d = rd_en_i ? rd_ptr_q + 1'b1 : rd_ptr_q;

    // NOTE: sequential state is always assigned with <= so every flop samples
    // the pre-edge values of its neighbours, independent of process order.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: the storage array has no reset; emptiness is defined by the
    // pointers alone, so clearing the entries would only add reset fan-out.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_ptr_q[aw_lp-1:0]] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_ptr_q[aw_lp-1:0]];
    assign empty_o   = (wr_ptr_q == rd_ptr_q);
    assign full_o    = (wr_ptr_q[aw_lp] != rd_ptr_q[aw_lp]) &&
                       (wr_ptr_q[aw_lp-1:0] == rd_ptr_q[aw_lp-1:0]);

endmodule

// File: rtl/vec_cmd_dispatch.sv
// -----------------------------------------------------------------------------
// vec_cmd_dispatch
// Command front-end for the vector accelerator core. Host commands are queued
// in vec_cmd_fifo and issued one at a time; the issued command sits in a hold
// register that drives every acc_* field, so the fields stay stable for the
// whole time the core is working on them. Read (OP_RD) results are captured
// and offered to the host on a valid/ready port; acc_yumi_o acknowledges them.
//
// Optional build macro: VEC_DISPATCH_OPCHECK_EN -- when defined, opcodes
// outside the legal set are dropped at the pop point and raise the sticky
// err_o flag. When undefined every opcode is issued and err_o is tied low.
//
// Ports:
//   clk_i, reset_ni              clock, asynchronous active-low reset
//   cmd_v_i / cmd_ready_o        host command handshake (ready = FIFO not full)
//   cmd_op_i, cmd_addr*_i,
//   cmd_scalar_i, cmd_w_data_i   command fields
//   acc_v_o / acc_ready_i        issue handshake to the core
//   acc_op_o .. acc_w_data_o     held command fields to the core
//   acc_done_i, acc_r_data_i     core completion and read data
//   acc_yumi_o                   read result consumed
//   res_v_o / res_ready_i,
//   res_data_o                   read result to host
//   idle_o                       FIFO empty and FSM idle
//   err_o                        sticky illegal-opcode flag
// -----------------------------------------------------------------------------
module vec_cmd_dispatch
    import vec_pkg::*;
#(
    parameter  int els_p           = VEC_ELS,
    parameter  int vlen_p          = VEC_LEN,
    parameter  int vdw_p           = VEC_DW,
    parameter  int fifo_els_p      = 4,
    localparam int v_addr_width_lp = $clog2(els_p)
) (
    input  logic                       clk_i,
    input  logic                       reset_ni,
    input  logic                       cmd_v_i,
    output logic                       cmd_ready_o,
    input  logic [3:0]                 cmd_op_i,
    input  logic [v_addr_width_lp-1:0] cmd_addrA_i,
    input  logic [v_addr_width_lp-1:0] cmd_addrB_i,
    input  logic [v_addr_width_lp-1:0] cmd_addrC_i,
    input  logic [v_addr_width_lp-1:0] cmd_addrD_i,
    input  logic [vdw_p-1:0]           cmd_scalar_i,
    input  logic [vlen_p*vdw_p-1:0]    cmd_w_data_i,
    output logic [3:0]                 acc_op_o,
    output logic [v_addr_width_lp-1:0] acc_addrA_o,
    output logic [v_addr_width_lp-1:0] acc_addrB_o,
    output logic [v_addr_width_lp-1:0] acc_addrC_o,
    output logic [v_addr_width_lp-1:0] acc_addrD_o,
    output logic [vdw_p-1:0]           acc_scalar_o,
    output logic [vlen_p*vdw_p-1:0]    acc_w_data_o,
    output logic                       acc_v_o,
    input  logic                       acc_ready_i,
    input  logic                       acc_done_i,
    input  logic [vlen_p*vdw_p-1:0]    acc_r_data_i,
    output logic                       acc_yumi_o,
    output logic                       res_v_o,
    output logic [vlen_p*vdw_p-1:0]    res_data_o,
    input  logic                       res_ready_i,
    output logic                       idle_o,
    output logic                       err_o
);

    disp_state_e              state_q, state_d;
    vec_cmd_s                 hold_q, hold_d;
    vec_cmd_s                 push_cmd, head_cmd;
    logic [vlen_p*vdw_p-1:0]  res_data_q, res_data_d;
    logic                     fifo_push, fifo_pop, fifo_full, fifo_empty;

    // Ready is gated by reset so the host sees no capacity while held in reset.
    assign cmd_ready_o = reset_ni & ~fifo_full;
    assign fifo_push   = cmd_v_i & cmd_ready_o;

    assign push_cmd = '{op:     cmd_op_i,
                        addr_a: cmd_addrA_i,
                        addr_b: cmd_addrB_i,
                        addr_c: cmd_addrC_i,
                        addr_d: cmd_addrD_i,
                        scalar: cmd_scalar_i,
                        w_data: cmd_w_data_i};

    vec_cmd_fifo #(.fifo_els_p(fifo_els_p)) u_fifo (
        .clk_i     (clk_i),
        .reset_ni  (reset_ni),
        .wr_en_i   (fifo_push),
        .wr_data_i (push_cmd),
        .rd_en_i   (fifo_pop),
        .rd_data_o (head_cmd),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

`ifdef VEC_DISPATCH_OPCHECK_EN
    logic err_q, err_d;
`endif

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        res_data_d = res_data_q;
        fifo_pop   = 1'b0;
        acc_v_o    = 1'b0;
        acc_yumi_o = 1'b0;
        res_v_o    = 1'b0;
`ifdef VEC_DISPATCH_OPCHECK_EN
        err_d      = err_q;
`endif
        unique case (state_q)
            s_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
`ifdef VEC_DISPATCH_OPCHECK_EN
                    if (is_legal_op(head_cmd.op)) begin
                        hold_d  = head_cmd;
                        state_d = s_ISSUE;
                    end else begin
                        err_d = 1'b1;
                    end
`else
                    hold_d  = head_cmd;
                    state_d = s_ISSUE;
`endif
                end
            end
            s_ISSUE: begin
                acc_v_o = 1'b1;
                if (acc_ready_i) state_d = s_BUSY;
            end
            s_BUSY: begin
                if (acc_done_i) begin
                    if (hold_q.op == OP_RD) begin
                        acc_yumi_o = 1'b1;
                        res_data_d = acc_r_data_i;
                        state_d    = s_RESP;
                    end else begin
                        state_d = s_IDLE;
                    end
                end
            end
            s_RESP: begin
                res_v_o = 1'b1;
                if (res_ready_i) state_d = s_IDLE;
            end
            default: state_d = s_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q    <= s_IDLE;
            hold_q     <= '0;
            res_data_q <= '0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            res_data_q <= res_data_d;
        end
    end

`ifdef VEC_DISPATCH_OPCHECK_EN
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) err_q <= 1'b0;
        else           err_q <= err_d;
    end
    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    assign acc_op_o     = hold_q.op;
    assign acc_addrA_o  = hold_q.addr_a;
    assign acc_addrB_o  = hold_q.addr_b;
    assign acc_addrC_o  = hold_q.addr_c;
    assign acc_addrD_o  = hold_q.addr_d;
    assign acc_scalar_o = hold_q.scalar;
    assign acc_w_data_o = hold_q.w_data;
    assign res_data_o   = res_data_q;
    assign idle_o       = fifo_empty & (state_q == s_IDLE);

endmodule

// File: tb/tb_vec_cmd_dispatch.sv
// -----------------------------------------------------------------------------
// tb_vec_cmd_dispatch
// Directed bench for vec_cmd_dispatch: reset values, single non-read issue
// with latency and field stability, read result path, FIFO fill and ordering,
// opcode checking (either build) and reset while the core is busy.
// -----------------------------------------------------------------------------
module tb_vec_cmd_dispatch;
    import vec_pkg::*;

    logic        clk_i = 1'b0;
    logic        reset_ni;
    logic        cmd_v_i;
    logic        cmd_ready_o;
    logic [3:0]  cmd_op_i;
    logic [2:0]  cmd_addrA_i, cmd_addrB_i, cmd_addrC_i, cmd_addrD_i;
    logic [7:0]  cmd_scalar_i;
    logic [63:0] cmd_w_data_i;
    logic [3:0]  acc_op_o;
    logic [2:0]  acc_addrA_o, acc_addrB_o, acc_addrC_o, acc_addrD_o;
    logic [7:0]  acc_scalar_o;
    logic [63:0] acc_w_data_o;
    logic        acc_v_o, acc_ready_i, acc_done_i, acc_yumi_o;
    logic [63:0] acc_r_data_i;
    logic        res_v_o, res_ready_i, idle_o, err_o;
    logic [63:0] res_data_o;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk_i = ~clk_i;

    vec_cmd_dispatch dut (
        .clk_i        (clk_i),
        .reset_ni     (reset_ni),
        .cmd_v_i      (cmd_v_i),
        .cmd_ready_o  (cmd_ready_o),
        .cmd_op_i     (cmd_op_i),
        .cmd_addrA_i  (cmd_addrA_i),
        .cmd_addrB_i  (cmd_addrB_i),
        .cmd_addrC_i  (cmd_addrC_i),
        .cmd_addrD_i  (cmd_addrD_i),
        .cmd_scalar_i (cmd_scalar_i),
        .cmd_w_data_i (cmd_w_data_i),
        .acc_op_o     (acc_op_o),
        .acc_addrA_o  (acc_addrA_o),
        .acc_addrB_o  (acc_addrB_o),
        .acc_addrC_o  (acc_addrC_o),
        .acc_addrD_o  (acc_addrD_o),
        .acc_scalar_o (acc_scalar_o),
        .acc_w_data_o (acc_w_data_o),
        .acc_v_o      (acc_v_o),
        .acc_ready_i  (acc_ready_i),
        .acc_done_i   (acc_done_i),
        .acc_r_data_i (acc_r_data_i),
        .acc_yumi_o   (acc_yumi_o),
        .res_v_o      (res_v_o),
        .res_data_o   (res_data_o),
        .res_ready_i  (res_ready_i),
        .idle_o       (idle_o),
        .err_o        (err_o)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_cmd(input logic v, input logic [3:0] op,
                           input logic [2:0] a, input logic [2:0] b,
                           input logic [2:0] c, input logic [2:0] d);
        cmd_v_i      = v;
        cmd_op_i     = op;
        cmd_addrA_i  = a;
        cmd_addrB_i  = b;
        cmd_addrC_i  = c;
        cmd_addrD_i  = d;
        cmd_scalar_i = {1'b0, a, 1'b0, d};
        cmd_w_data_i = {16{op}};
    endtask

    // Advances until acc_v_o is seen high or the budget runs out.
    task automatic wait_acc_v(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (acc_v_o === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        reset_ni = 1'b0;
        set_cmd(1'b0, 4'h0, 3'd0, 3'd0, 3'd0, 3'd0);
        acc_ready_i = 1'b0; acc_done_i = 1'b0; acc_r_data_i = '0; res_ready_i = 1'b0;
        #1;
        n_vec++;
        if ({cmd_ready_o, acc_v_o, res_v_o, acc_yumi_o, err_o} !== 5'b00000) begin
            n_err++; $display("FAIL rst_ctrl: got %b want 00000", {cmd_ready_o, acc_v_o, res_v_o, acc_yumi_o, err_o});
        end
        n_vec++;
        if ({acc_op_o, acc_addrA_o, acc_addrB_o, acc_addrC_o, acc_addrD_o, acc_scalar_o, acc_w_data_o, res_data_o} !== '0) begin
            n_err++; $display("FAIL rst_fields: acc/res fields not zero (op %h res %h)", acc_op_o, res_data_o);
        end
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        reset_ni = 1'b1;
        tick();
        n_vec++;
        if ({cmd_ready_o, idle_o, acc_v_o, res_v_o} !== 4'b1100) begin
            n_err++; $display("FAIL rst_release: got %b want 1100", {cmd_ready_o, idle_o, acc_v_o, res_v_o});
        end
        acc_done_i = 1'b1;  // must be ignored outside s_BUSY
        #1;
        n_vec++;
        if (acc_yumi_o !== 1'b0) begin
            n_err++; $display("FAIL idle_done_yumi: got %b want 0", acc_yumi_o);
        end
        tick();
        acc_done_i = 1'b0;
        n_vec++;
        if ({res_v_o, acc_v_o, idle_o} !== 3'b001) begin
            n_err++; $display("FAIL idle_done_state: got %b want 001", {res_v_o, acc_v_o, idle_o});
        end
    endtask

    task automatic test_add();
        acc_ready_i = 1'b1;
        set_cmd(1'b1, OP_ADD, 3'd1, 3'd2, 3'd0, 3'd3);   // cycle 0
        n_vec++;
        if (cmd_ready_o !== 1'b1) begin
            n_err++; $display("FAIL add_ready: got %b want 1", cmd_ready_o);
        end
        tick();                                          // cycle 1
        cmd_v_i = 1'b0;
        n_vec++;
        if (acc_v_o !== 1'b0) begin
            n_err++; $display("FAIL add_lat_c1: acc_v got %b want 0", acc_v_o);
        end
        tick();                                          // cycle 2
        n_vec++;
        if (acc_v_o !== 1'b1) begin
            n_err++; $display("FAIL add_lat_c2: acc_v got %b want 1", acc_v_o);
        end
        n_vec++;
        if ({acc_op_o, acc_addrA_o, acc_addrB_o, acc_addrD_o} !== {4'h0, 3'd1, 3'd2, 3'd3}) begin
            n_err++; $display("FAIL add_fields_issue: got %h/%0d/%0d/%0d want 0/1/2/3", acc_op_o, acc_addrA_o, acc_addrB_o, acc_addrD_o);
        end
        tick();                                          // now busy
        acc_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if ({acc_v_o, acc_op_o, acc_addrA_o, acc_addrB_o, acc_addrD_o} !== {1'b0, 4'h0, 3'd1, 3'd2, 3'd3}) begin
                n_err++; $display("FAIL add_fields_busy%0d: v %b op %h A %0d B %0d D %0d want 0/0/1/2/3", i, acc_v_o, acc_op_o, acc_addrA_o, acc_addrB_o, acc_addrD_o);
            end
            tick();
        end
        acc_done_i = 1'b1;
        #1;
        n_vec++;
        if (acc_yumi_o !== 1'b0) begin
            n_err++; $display("FAIL add_yumi: got %b want 0", acc_yumi_o);
        end
        tick();
        acc_done_i = 1'b0;
        n_vec++;
        if ({idle_o, res_v_o, acc_v_o} !== 3'b100) begin
            n_err++; $display("FAIL add_done: idle/res_v/acc_v got %b want 100", {idle_o, res_v_o, acc_v_o});
        end
    endtask

    task automatic test_read();
        bit ok;
        acc_ready_i = 1'b1;
        set_cmd(1'b1, OP_RD, 3'd5, 3'd0, 3'd0, 3'd0);
        tick();
        cmd_v_i = 1'b0;
        wait_acc_v(ok);
        n_vec++;
        if (!ok || acc_op_o !== OP_RD || acc_addrA_o !== 3'd5) begin
            n_err++; $display("FAIL rd_issue: seen %b op %h A %0d want 1/8/5", ok, acc_op_o, acc_addrA_o);
        end
        tick();
        acc_ready_i  = 1'b0;
        acc_done_i   = 1'b1;
        acc_r_data_i = 64'h0123456789ABCDEF;
        #1;
        n_vec++;
        if (acc_yumi_o !== 1'b1) begin
            n_err++; $display("FAIL rd_yumi: got %b want 1", acc_yumi_o);
        end
        tick();
        acc_done_i   = 1'b0;
        acc_r_data_i = 64'hFFFF_0000_FFFF_0000;      // must not leak into res_data_o
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if ({res_v_o, acc_yumi_o} !== 2'b10 || res_data_o !== 64'h0123456789ABCDEF) begin
                n_err++; $display("FAIL rd_hold%0d: v %b yumi %b data %h want 1/0/0123456789abcdef", i, res_v_o, acc_yumi_o, res_data_o);
            end
            tick();
        end
        res_ready_i = 1'b1;
        #1;
        n_vec++;
        if (res_v_o !== 1'b1) begin
            n_err++; $display("FAIL rd_accept_cycle: res_v got %b want 1", res_v_o);
        end
        tick();
        res_ready_i = 1'b0;
        n_vec++;
        if ({res_v_o, idle_o} !== 2'b01) begin
            n_err++; $display("FAIL rd_release: res_v/idle got %b want 01", {res_v_o, idle_o});
        end
    endtask

    task automatic test_fill();
        bit ok;
        logic [3:0] ops [5];
        ops[0] = OP_ADD; ops[1] = OP_SUB; ops[2] = OP_MUL; ops[3] = OP_FMA; ops[4] = OP_WR;
        acc_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_cmd(1'b1, ops[i], 3'(i + 1), 3'd0, 3'd0, 3'(i));
            n_vec++;
            if (cmd_ready_o !== 1'b1) begin
                n_err++; $display("FAIL fill_ready%0d: got %b want 1", i, cmd_ready_o);
            end
            tick();
        end
        cmd_v_i = 1'b0;
        n_vec++;
        if ({cmd_ready_o, acc_v_o, acc_addrD_o} !== {1'b0, 1'b1, 3'd0}) begin
            n_err++; $display("FAIL fill_full: ready %b acc_v %b D %0d want 0/1/0", cmd_ready_o, acc_v_o, acc_addrD_o);
        end
        for (int k = 0; k < 5; k++) begin
            wait_acc_v(ok);
            n_vec++;
            if (!ok || acc_op_o !== ops[k] || acc_addrD_o !== 3'(k) || acc_addrA_o !== 3'(k + 1)) begin
                n_err++; $display("FAIL fill_order%0d: seen %b op %h D %0d A %0d want op %h D %0d", k, ok, acc_op_o, acc_addrD_o, acc_addrA_o, ops[k], k);
            end
            if (k == 1) begin
                n_vec++;
                if (cmd_ready_o !== 1'b1) begin
                    n_err++; $display("FAIL fill_ready_rise: got %b want 1", cmd_ready_o);
                end
            end
            acc_ready_i = 1'b1;
            tick();
            acc_ready_i = 1'b0;
            acc_done_i  = 1'b1;
            tick();
            acc_done_i  = 1'b0;
            if (k == 0) begin
                n_vec++;
                if (cmd_ready_o !== 1'b0) begin
                    n_err++; $display("FAIL fill_still_full: got %b want 0", cmd_ready_o);
                end
            end
        end
        n_vec++;
        if (idle_o !== 1'b1) begin
            n_err++; $display("FAIL fill_drained: idle got %b want 1", idle_o);
        end
    endtask

`ifdef VEC_DISPATCH_OPCHECK_EN
    task automatic test_opcheck();
        bit ok;
        acc_ready_i = 1'b1;
        set_cmd(1'b1, 4'hF, 3'd0, 3'd0, 3'd0, 3'd7);
        tick();
        set_cmd(1'b1, OP_ADD, 3'd0, 3'd0, 3'd0, 3'd6);
        tick();
        cmd_v_i = 1'b0;
        wait_acc_v(ok);
        n_vec++;
        if (!ok || acc_op_o !== OP_ADD || acc_addrD_o !== 3'd6) begin
            n_err++; $display("FAIL opchk_issue: seen %b op %h D %0d want 1/0/6", ok, acc_op_o, acc_addrD_o);
        end
        n_vec++;
        if (err_o !== 1'b1) begin
            n_err++; $display("FAIL opchk_err: got %b want 1", err_o);
        end
        tick();
        acc_ready_i = 1'b0;
        acc_done_i  = 1'b1;
        tick();
        acc_done_i  = 1'b0;
        repeat (2) tick();
        n_vec++;
        if ({err_o, idle_o, acc_v_o} !== 3'b110) begin
            n_err++; $display("FAIL opchk_sticky: err/idle/acc_v got %b want 110", {err_o, idle_o, acc_v_o});
        end
    endtask
`else
    task automatic test_no_opcheck();
        bit ok;
        acc_ready_i = 1'b1;
        set_cmd(1'b1, 4'hF, 3'd0, 3'd0, 3'd0, 3'd7);
        tick();
        cmd_v_i = 1'b0;
        wait_acc_v(ok);
        n_vec++;
        if (!ok || acc_op_o !== 4'hF || acc_addrD_o !== 3'd7 || err_o !== 1'b0) begin
            n_err++; $display("FAIL noopchk_issue: seen %b op %h D %0d err %b want 1/f/7/0", ok, acc_op_o, acc_addrD_o, err_o);
        end
        tick();
        acc_ready_i = 1'b0;
        acc_done_i  = 1'b1;
        tick();
        acc_done_i  = 1'b0;
        n_vec++;
        if ({idle_o, res_v_o, err_o} !== 3'b100) begin
            n_err++; $display("FAIL noopchk_done: idle/res_v/err got %b want 100", {idle_o, res_v_o, err_o});
        end
    endtask
`endif

    task automatic test_reset_busy();
        bit ok;
        acc_ready_i = 1'b1;
        set_cmd(1'b1, OP_ADD, 3'd4, 3'd5, 3'd6, 3'd7);
        tick();
        set_cmd(1'b1, OP_SUB, 3'd1, 3'd1, 3'd1, 3'd1);  // left queued
        tick();
        cmd_v_i = 1'b0;
        wait_acc_v(ok);
        tick();
        acc_ready_i = 1'b0;
        n_vec++;
        if (!ok || {acc_v_o, acc_addrA_o, acc_addrC_o} !== {1'b0, 3'd4, 3'd6}) begin
            n_err++; $display("FAIL rstbusy_pre: seen %b v %b A %0d C %0d want 1/0/4/6", ok, acc_v_o, acc_addrA_o, acc_addrC_o);
        end
        #2;
        reset_ni = 1'b0;                               // mid-cycle, no clock edge
        #1;
        n_vec++;
        if ({acc_v_o, res_v_o, acc_yumi_o, cmd_ready_o} !== 4'b0000 ||
            {acc_op_o, acc_addrA_o, acc_addrB_o, acc_addrC_o, acc_addrD_o, acc_scalar_o, acc_w_data_o} !== '0) begin
            n_err++; $display("FAIL rstbusy_async: v %b res %b A %0d C %0d ready %b want all 0", acc_v_o, res_v_o, acc_addrA_o, acc_addrC_o, cmd_ready_o);
        end
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        reset_ni = 1'b1;
        tick();
        acc_done_i   = 1'b1;
        acc_r_data_i = 64'hA5A5_A5A5_A5A5_A5A5;
        #1;
        n_vec++;
        if ({acc_yumi_o, cmd_ready_o, idle_o} !== 3'b011) begin
            n_err++; $display("FAIL rstbusy_post: yumi/ready/idle got %b want 011", {acc_yumi_o, cmd_ready_o, idle_o});
        end
        tick();
        acc_done_i = 1'b0;
        tick();
        n_vec++;
        if ({res_v_o, acc_v_o, idle_o} !== 3'b001 || res_data_o !== 64'd0) begin
            n_err++; $display("FAIL rstbusy_flushed: res_v/acc_v/idle %b data %h want 001/0", {res_v_o, acc_v_o, idle_o}, res_data_o);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_read();
        test_fill();
`ifdef VEC_DISPATCH_OPCHECK_EN
        test_opcheck();
`else
        test_no_opcheck();
`endif
        test_reset_busy();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
